// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM states and slice width.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

endpackage

// File: rtl/serial_addsub_carry4.sv
// Behavioural model of the CARRY4 4-bit carry-chain primitive used as the adder slice.
module CARRY4 (
   input  logic [3:0] S,
   input  logic [3:0] DI,
   input  logic       CI,
   input  logic       CYINIT,
   output logic [3:0] O,
   output logic [3:0] CO
);

   logic [4:0] chain;

   // Each stage propagates the incoming carry when S is set, otherwise generates DI.
   always_comb begin
      chain    = '0;
      chain[0] = CI | CYINIT;
      for (int i = 0; i < 4; i++) begin
         O[i]         = S[i] ^ chain[i];
         chain[i + 1] = S[i] ? chain[i] : DI[i];
      end
      CO = chain[4:1];
   end

endmodule

// File: rtl/serial_addsub.sv
// Nibble-serial add/subtract unit: one 4-bit CARRY4 slice per BUSY cycle, LSB first.
// Define SERIAL_ADDSUB_FLAGS_EN to add registered zero_o / negative_o result flags.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH_P = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH_P-1:0] a_i,
   input  logic [WIDTH_P-1:0] b_i,
   input  logic               sub_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [WIDTH_P-1:0] sum_o,
   output logic               carry_o,
   output logic               overflow_o
`ifdef SERIAL_ADDSUB_FLAGS_EN
   ,
   output logic               zero_o,
   output logic               negative_o
`endif
);

   localparam int N     = WIDTH_P / NIBBLE_W;
   localparam int CNT_W = $clog2(N);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH_P-1:0]   a_q;
   logic [WIDTH_P-1:0]   b_q;
   logic                 carry_q;
   logic [WIDTH_P-1:0]   sum_q;
   logic [WIDTH_P-1:0]   sum_next;
   logic [NIBBLE_W-1:0]  a_nib;
   logic [NIBBLE_W-1:0]  b_nib;
   logic [NIBBLE_W-1:0]  slice_o;
   logic [NIBBLE_W-1:0]  slice_co;
   logic                 last;
   logic                 unused_co;

   assign a_nib     = a_q[int'(cnt) * NIBBLE_W +: NIBBLE_W];
   assign b_nib     = b_q[int'(cnt) * NIBBLE_W +: NIBBLE_W];
   assign last      = (cnt == CNT_W'(N - 1));
   assign unused_co = ^slice_co[1:0];

   CARRY4 u_slice (
      .S      (a_nib ^ b_nib),
      .DI     (a_nib),
      .CI     (carry_q),
      .CYINIT (1'b0),
      .O      (slice_o),
      .CO     (slice_co)
   );

   // Result with the current nibble merged in, so flags can be taken from the final value.
   always_comb begin
      sum_next = sum_q;
      sum_next[int'(cnt) * NIBBLE_W +: NIBBLE_W] = slice_o;
   end

   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);
   assign sum_o   = sum_q;

   // Subtraction is a + ~b + 1: b is inverted on capture and the carry chain seeded with 1.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         sum_q      <= '0;
         carry_o    <= 1'b0;
         overflow_o <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
         zero_o     <= 1'b0;
         negative_o <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i ^ {WIDTH_P{sub_i}};
                  carry_q <= sub_i;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               sum_q   <= sum_next;
               carry_q <= slice_co[3];
               if (last) begin
                  state      <= DONE;
                  carry_o    <= slice_co[3];
                  overflow_o <= slice_co[3] ^ slice_co[2];
`ifdef SERIAL_ADDSUB_FLAGS_EN
                  zero_o     <= (sum_next == '0);
                  negative_o <= sum_next[WIDTH_P-1];
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH_P = 32): directed table, corner sequences, random ops.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        sub_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] sum_o;
   logic        carry_o;
   logic        overflow_o;
   logic        zero_o;
   logic        negative_o;

   int tests  = 0;
   int errors = 0;

   serial_addsub #(.WIDTH_P(32)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .a_i        (a_i),
      .b_i        (b_i),
      .sub_i      (sub_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .sum_o      (sum_o),
      .carry_o    (carry_o),
      .overflow_o (overflow_o)
`ifdef SERIAL_ADDSUB_FLAGS_EN
      ,
      .zero_o     (zero_o),
      .negative_o (negative_o)
`endif
   );

`ifndef SERIAL_ADDSUB_FLAGS_EN
   assign zero_o     = 1'b0;
   assign negative_o = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } vec_t;

   vec_t vecs[8];

   // Reference: plain 33-bit arithmetic, subtraction as a + ~b + 1; returns {ovf, carry, sum}.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic [32:0] r;
      logic        ovf;
      if (sub) begin
         r   = {1'b0, a} + {1'b0, ~b} + 33'd1;
         ovf = (a[31] != b[31]) && (r[31] != a[31]);
      end else begin
         r   = {1'b0, a} + {1'b0, b};
         ovf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      return {ovf, r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Launch one request; lat counts rising edges with the accept edge as edge 1.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output int lat);
      a_i     = a;
      b_i     = b;
      sub_i   = sub;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic releaseResult();
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
   endtask

   task automatic checkOp(input string name, input logic [31:0] a, input logic [31:0] b, input logic sub);
      int          lat;
      logic [33:0] exp;
      exp = model(a, b, sub);
      applyStimulus(a, b, sub, lat);
      checkOutput({name, " latency"}, 32'(lat), 32'd9);
      checkOutput({name, " sum"}, sum_o, exp[31:0]);
      checkOutput({name, " carry"}, {31'd0, carry_o}, {31'd0, exp[32]});
      checkOutput({name, " ovf"}, {31'd0, overflow_o}, {31'd0, exp[33]});
`ifdef SERIAL_ADDSUB_FLAGS_EN
      checkOutput({name, " zero"}, {31'd0, zero_o}, {31'd0, exp[31:0] == 32'd0});
      checkOutput({name, " neg"}, {31'd0, negative_o}, {31'd0, exp[31]});
`endif
      releaseResult();
   endtask

   initial begin
      int          lat;
      logic [31:0] held_sum;
      logic        held_c;
      logic        held_v;

      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      sub_i   = 1'b0;

      vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[4] = '{32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
      vecs[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      checkOutput("reset ready", {31'd0, ready_o}, 32'd1);
      checkOutput("reset valid", {31'd0, valid_o}, 32'd0);
      checkOutput("reset sum", sum_o, 32'd0);
      checkOutput("reset carry", {31'd0, carry_o}, 32'd0);
      checkOutput("reset ovf", {31'd0, overflow_o}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
         checkOutput($sformatf("vec%0d sum", i), sum_o, vecs[i].sum);
         checkOutput($sformatf("vec%0d carry", i), {31'd0, carry_o}, {31'd0, vecs[i].carry});
         checkOutput($sformatf("vec%0d ovf", i), {31'd0, overflow_o}, {31'd0, vecs[i].ovf});
`ifdef SERIAL_ADDSUB_FLAGS_EN
         checkOutput($sformatf("vec%0d zero", i), {31'd0, zero_o}, {31'd0, vecs[i].sum == 32'd0});
         checkOutput($sformatf("vec%0d neg", i), {31'd0, negative_o}, {31'd0, vecs[i].sum[31]});
`endif
         releaseResult();
         checkOutput($sformatf("vec%0d back to idle", i), {31'd0, ready_o}, 32'd1);
      end

      // Backpressure: hold the result five cycles while new requests are offered.
      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      held_sum = sum_o;
      held_c   = carry_o;
      held_v   = overflow_o;
      checkOutput("hold initial sum", held_sum, 32'h8000_0000);
      for (int i = 0; i < 5; i++) begin
         a_i     = $urandom;
         b_i     = $urandom;
         sub_i   = 1'($urandom);
         valid_i = i[0];
         @(posedge clk);
         #1;
         checkOutput($sformatf("hold%0d valid", i), {31'd0, valid_o}, 32'd1);
         checkOutput($sformatf("hold%0d ready", i), {31'd0, ready_o}, 32'd0);
         checkOutput($sformatf("hold%0d sum", i), sum_o, held_sum);
         checkOutput($sformatf("hold%0d flags", i), {30'd0, carry_o, overflow_o}, {30'd0, held_c, held_v});
      end
      valid_i = 1'b1;
      releaseResult();
      valid_i = 1'b0;
      checkOutput("release ready", {31'd0, ready_o}, 32'd1);
      checkOutput("release valid", {31'd0, valid_o}, 32'd0);

      // Reset in the middle of BUSY with counter at 3, while valid_i is also high.
      a_i     = 32'd7;
      b_i     = 32'd9;
      sub_i   = 1'b0;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b1;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      valid_i = 1'b0;
      checkOutput("midreset ready", {31'd0, ready_o}, 32'd1);
      checkOutput("midreset valid", {31'd0, valid_o}, 32'd0);
      checkOutput("midreset sum", sum_o, 32'd0);
      checkOp("after reset 2+3", 32'd2, 32'd3, 1'b0);

      for (int i = 0; i < 30; i++) begin
         checkOp($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
